// File: rtl/reg_bank_mp.sv
`timescale 1ns/1ps
// reg_bank_mp: parametrised register bank with one write port and two
// registered read ports, write-first bypass and optional zero register 0.
module reg_bank_mp #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 8,
    parameter int AW        = $clog2(DEPTH),
    parameter int ZERO_REG0 = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re_a,
    input  logic [AW-1:0]    raddr_a,
    output logic [WIDTH-1:0] rdata_a,
    output logic             rvalid_a,
    input  logic             re_b,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] rdata_b,
    output logic             rvalid_b
);

    localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
    localparam bit          Z0      = (ZERO_REG0 != 0);

    logic [WIDTH-1:0] mem [DEPTH];
    logic             wr_ok;
    logic [WIDTH-1:0] val_a;
    logic [WIDTH-1:0] val_b;

    // A dropped write must never reach the bypass path either.
    always_comb begin
        wr_ok = we
              && ({1'b0, waddr} < DEPTH_W)
              && !(Z0 && (waddr == '0));
    end

    always_comb begin
        val_a = '0;
        if ({1'b0, raddr_a} >= DEPTH_W) begin
            val_a = '0;
        end else if (Z0 && (raddr_a == '0)) begin
            val_a = '0;
        end else if (wr_ok && (waddr == raddr_a)) begin
            val_a = wdata;
        end else begin
            val_a = mem[raddr_a];
        end
    end

    always_comb begin
        val_b = '0;
        if ({1'b0, raddr_b} >= DEPTH_W) begin
            val_b = '0;
        end else if (Z0 && (raddr_b == '0)) begin
            val_b = '0;
        end else if (wr_ok && (waddr == raddr_b)) begin
            val_b = wdata;
        end else begin
            val_b = mem[raddr_b];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    // rdata holds its last value when no read is requested.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_a  <= '0;
            rvalid_a <= 1'b0;
            rdata_b  <= '0;
            rvalid_b <= 1'b0;
        end else begin
            rvalid_a <= re_a;
            rvalid_b <= re_b;
            if (re_a) begin
                rdata_a <= val_a;
            end
            if (re_b) begin
                rdata_b <= val_b;
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_mp.sv
`timescale 1ns/1ps
// tb_reg_bank_mp: two banks (8 regs plain, 6 regs with zero reg) driven
// by the same stimulus and compared against an array-based model.
module tb_reg_bank_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic        re_a;
    logic [2:0]  raddr_a;
    logic        re_b;
    logic [2:0]  raddr_b;

    logic [31:0] rda [2];
    logic [31:0] rdb [2];
    logic        rva [2];
    logic        rvb [2];

    int checks   = 0;
    int failures = 0;

    logic [31:0] mm [2][8];
    logic [31:0] ed [2][2];
    logic        ev [2][2];
    int          dep [2] = '{8, 6};
    bit          zr  [2] = '{1'b0, 1'b1};

    always #5 clk = ~clk;

    reg_bank_mp #(.WIDTH(32), .DEPTH(8), .ZERO_REG0(0)) u_d8 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rda[0]), .rvalid_a(rva[0]),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdb[0]), .rvalid_b(rvb[0])
    );

    reg_bank_mp #(.WIDTH(32), .DEPTH(6), .ZERO_REG0(1)) u_d6 (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rda[1]), .rvalid_a(rva[1]),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdb[1]), .rvalid_b(rvb[1])
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(int k, int a, bit wok);
        if (a >= dep[k]) return 32'h0;
        if (zr[k] && a == 0) return 32'h0;
        if (wok && int'(waddr) == a) return wdata;
        return mm[k][a];
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            bit wok;
            wok = we && (int'(waddr) < dep[k]) && !(zr[k] && waddr == 3'd0);
            for (int p = 0; p < 2; p++) begin
                bit rq;
                int a;
                rq = (p == 0) ? re_a : re_b;
                a  = (p == 0) ? int'(raddr_a) : int'(raddr_b);
                ev[k][p] = rq;
                if (rq) ed[k][p] = ref_read(k, a, wok);
            end
            if (wok) mm[k][waddr] = wdata;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 8; i++) mm[k][i] = 32'h0;
            for (int p = 0; p < 2; p++) begin
                ed[k][p] = 32'h0;
                ev[k][p] = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            check($sformatf("u%0d_a_data", k), rda[k], ed[k][0]);
            check($sformatf("u%0d_b_data", k), rdb[k], ed[k][1]);
            check($sformatf("u%0d_a_valid", k), {31'b0, rva[k]}, {31'b0, ev[k][0]});
            check($sformatf("u%0d_b_valid", k), {31'b0, rvb[k]}, {31'b0, ev[k][1]});
        end
    endtask

    task automatic cycle(input logic w, input logic [2:0] wa,
                         input logic [31:0] wd, input logic ea,
                         input logic [2:0] ra, input logic eb,
                         input logic [2:0] rb);
        we = w; waddr = wa; wdata = wd;
        re_a = ea; raddr_a = ra;
        re_b = eb; raddr_b = rb;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    // Reset is raised mid-cycle and must clear outputs with no clock edge.
    task automatic pulse_reset(input int hold);
        reset = 1'b1;
        #2;
        model_reset();
        check_all();
        repeat (hold) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        we = 0; waddr = 0; wdata = 0;
        re_a = 0; raddr_a = 0; re_b = 0; raddr_b = 0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        reset = 1'b0;

        cycle(1, 3'd3, 32'hDEADBEEF, 0, 3'd0, 0, 3'd0);
        cycle(0, 3'd0, 32'h0, 1, 3'd3, 1, 3'd3);
        check("t1_r3_before", rda[0], 32'hDEADBEEF);
        pulse_reset(1);
        cycle(0, 3'd0, 32'h0, 1, 3'd3, 1, 3'd3);
        check("t1_r3_after_u0", rda[0], 32'h0);
        check("t1_r3_after_u1", rdb[1], 32'h0);

        cycle(1, 3'd5, 32'h12345678, 0, 3'd0, 0, 3'd0);
        cycle(0, 3'd0, 32'h0, 1, 3'd5, 0, 3'd0);
        check("t2_data", rda[0], 32'h12345678);
        check("t2_valid", {31'b0, rva[0]}, 32'd1);

        cycle(1, 3'd2, 32'hA5A5A5A5, 1, 3'd2, 1, 3'd2);
        check("t3_byp_a", rda[0], 32'hA5A5A5A5);
        check("t3_byp_b", rdb[0], 32'hA5A5A5A5);
        check("t3_byp_u1b", rdb[1], 32'hA5A5A5A5);
        cycle(0, 3'd0, 32'h0, 1, 3'd2, 0, 3'd0);
        check("t3_after", rda[0], 32'hA5A5A5A5);

        cycle(1, 3'd0, 32'hFFFFFFFF, 1, 3'd0, 1, 3'd0);
        check("t4_nozero", rda[0], 32'hFFFFFFFF);
        check("t4_zero", rda[1], 32'h0);

        cycle(1, 3'd7, 32'h1, 1, 3'd7, 0, 3'd0);
        check("t5_oor_data", rda[1], 32'h0);
        check("t5_oor_valid", {31'b0, rva[1]}, 32'd1);
        check("t5_d8_byp", rda[0], 32'h1);
        for (int i = 0; i < 6; i++) begin
            cycle(0, 3'd0, 32'h0, 1, 3'(i), 1, 3'(5 - i));
        end

        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                we = 1'($urandom); waddr = 3'($urandom); wdata = $urandom;
                re_a = 1'($urandom); re_b = 1'($urandom);
                pulse_reset(int'($urandom_range(1, 3)));
            end else begin
                cycle(1'($urandom), 3'($urandom), $urandom,
                      1'($urandom), 3'($urandom),
                      1'($urandom), 3'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
